// File: rtl/reg_file_32x32.sv
// Two-read, one-write register file with a per-register pending scoreboard.
// Reads are combinational with same-cycle write bypass; r0 is hardwired to zero.

module reg_file_rd_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  localparam int DEPTH = 2 ** ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]             raddr,
  input  logic                              we,
  input  logic [ADDR_WIDTH-1:0]             waddr,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0]  regs,
  input  logic [DEPTH-1:0]                  pending,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic                              pend
);
  logic hit;
  logic zero;

  assign zero = (raddr == '0);
  assign hit  = we && (waddr == raddr) && !zero;

  always_comb begin
    rdata = regs[raddr];
    if (zero)     rdata = '0;
    else if (hit) rdata = wdata;
  end

  // An arriving write resolves the hazard in the same cycle it lands.
  assign pend = pending[raddr] && !hit;
endmodule

module reg_file_32x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rsv,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  pend_a,
  output logic                  pend_b
);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NUM_RD = 2;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
  logic [DEPTH-1:0]                 pending;

  logic                             wr_go;
  logic                             rsv_go;
  logic [DEPTH-1:0]                 wr_sel;
  logic [DEPTH-1:0]                 rsv_sel;
  logic [DEPTH-1:0]                 pending_nxt;

  assign wr_go  = we  && (waddr    != '0);
  assign rsv_go = rsv && (rsv_addr != '0);

  always_comb begin
    wr_sel  = '0;
    rsv_sel = '0;
    if (wr_go)  wr_sel[waddr]     = 1'b1;
    if (rsv_go) rsv_sel[rsv_addr] = 1'b1;
  end

  // Reserve is applied after the clear, so a newer producer keeps ownership.
  assign pending_nxt = (pending & ~wr_sel) | rsv_sel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      regs    <= '0;
      pending <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++)
        if (wr_sel[i]) regs[i] <= wdata;
      pending <= pending_nxt;
    end
  end

  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]                 rd_pend;

  assign rd_addr = {raddr_b, raddr_a};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_rd_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_port (
      .raddr  (rd_addr[p]),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .regs   (regs),
      .pending(pending),
      .rdata  (rd_data[p]),
      .pend   (rd_pend[p])
    );
  end

  assign rdata_a = rd_data[0];
  assign rdata_b = rd_data[1];
  assign pend_a  = rd_pend[0];
  assign pend_b  = rd_pend[1];
endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed literal checks plus randomized traffic compared each cycle
// against an array-based model of the register file.

module tb_reg_file_32x32;
  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        rsv;
  logic [4:0]  rsv_addr;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic        pend_a;
  logic        pend_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_reg  [32];
  bit          m_pend [32];
  bit          model_ok = 1'b0;

  always #5 clk = ~clk;

  reg_file_32x32 dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .rsv     (rsv),
    .rsv_addr(rsv_addr),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .pend_a  (pend_a),
    .pend_b  (pend_b)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model state advances on each rising edge from the inputs held across it.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = 32'h0;
        m_pend[i] = 1'b0;
      end
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (we && waddr != 0) begin
        m_reg[waddr]  = wdata;
        m_pend[waddr] = 1'b0;
      end
      if (rsv && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we && waddr == a) return wdata;
    return m_reg[a];
  endfunction

  function automatic logic exp_pd(input logic [4:0] a);
    return m_pend[a] && !(we && waddr == a);
  endfunction

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_rdata_a", rdata_a, exp_rd(raddr_a));
      chk("model_rdata_b", rdata_b, exp_rd(raddr_b));
      chk("model_pend_a", {31'h0, pend_a}, {31'h0, exp_pd(raddr_a)});
      chk("model_pend_b", {31'h0, pend_b}, {31'h0, exp_pd(raddr_b)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; rsv = 1'b0; rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    rsv = 1'b0; rsv_addr = '0; raddr_a = '0; raddr_b = '0;
    tick();

    // Reset discards a stored value
    idle(); we = 1'b1; waddr = 5; wdata = 32'hDEADBEEF; tick();
    idle(); raddr_a = 5; #1;
    chk("r5_before_reset", rdata_a, 32'hDEADBEEF);
    rst = 1'b0; tick();
    idle(); #1;
    chk("r5_after_reset", rdata_a, 32'h0);
    chk("r5_pend_after_reset", {31'h0, pend_a}, 32'h0);

    // Write and readback on both ports
    we = 1'b1; waddr = 1; wdata = 32'h00000011; tick();
    waddr = 31; wdata = 32'hFFFFFFFF; tick();
    idle(); raddr_a = 1; raddr_b = 31; #1;
    chk("r1_readback", rdata_a, 32'h00000011);
    chk("r31_readback", rdata_b, 32'hFFFFFFFF);

    // Register 0 ignores writes and reservations
    we = 1'b1; waddr = 0; wdata = 32'h12345678; rsv = 1'b1; rsv_addr = 0;
    raddr_a = 0; #1;
    chk("r0_same_cycle", rdata_a, 32'h0);
    chk("r0_pend_same_cycle", {31'h0, pend_a}, 32'h0);
    tick(); idle(); #1;
    chk("r0_next_cycle", rdata_a, 32'h0);
    chk("r0_pend_next_cycle", {31'h0, pend_a}, 32'h0);

    // Bypass
    we = 1'b1; waddr = 7; wdata = 32'hA; tick();
    waddr = 7; wdata = 32'hB; raddr_a = 7; raddr_b = 7; #1;
    chk("bypass_a", rdata_a, 32'hB);
    chk("bypass_b", rdata_b, 32'hB);
    tick(); idle(); #1;
    chk("bypass_stored", rdata_a, 32'hB);

    // Scoreboard set and same-cycle resolve
    rsv = 1'b1; rsv_addr = 9; raddr_a = 9; #1;
    chk("rsv_not_yet_visible", {31'h0, pend_a}, 32'h0);
    tick(); idle(); #1;
    chk("rsv_pending", {31'h0, pend_a}, 32'h1);
    we = 1'b1; waddr = 9; wdata = 32'h55; #1;
    chk("resolve_pend", {31'h0, pend_a}, 32'h0);
    chk("resolve_data", rdata_a, 32'h55);
    tick(); idle(); #1;
    chk("resolved_next", {31'h0, pend_a}, 32'h0);
    chk("resolved_data_next", rdata_a, 32'h55);

    // Write/reserve collision: reserve wins, data still lands
    rsv = 1'b1; rsv_addr = 4; tick();
    we = 1'b1; waddr = 4; wdata = 32'h77; rsv = 1'b1; rsv_addr = 4; tick();
    idle(); raddr_a = 4; raddr_b = 4; #1;
    chk("collision_data", rdata_a, 32'h77);
    chk("collision_pend", {31'h0, pend_b}, 32'h1);
    rst = 1'b0; tick(); idle(); #1;
    chk("collision_reset_pend", {31'h0, pend_a}, 32'h0);
    chk("collision_reset_data", rdata_b, 32'h0);

    // Randomized traffic; narrow address ranges force collisions
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] mask;
      mask = ($urandom_range(0, 1) == 1) ? 5'h07 : 5'h1F;
      rst      = ($urandom_range(0, 99) != 0);
      we       = $urandom_range(0, 1);
      waddr    = 5'($urandom) & mask;
      wdata    = $urandom;
      rsv      = ($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom) & mask;
      raddr_a  = 5'($urandom) & mask;
      raddr_b  = ($urandom_range(0, 3) == 0) ? raddr_a : 5'($urandom) & mask;
      tick();
    end

    idle(); tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_32x32.md
# reg_file_32x32

Two-read, one-write register file of thirty-two 32-bit registers, built as the storage array that the datapath's 32-bit registers populate. It sits between instruction decode (read addresses, reservations) and writeback (write port), and supplies ALU operands. Writes bypass to same-cycle reads. A per-register pending scoreboard lets decode detect operands whose producer has not yet written back.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each register and of all data buses
- ADDR_WIDTH, 5, register address width; depth is 2**ADDR_WIDTH

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-low; sampled on rising edge of clk
- we  input  1  write enable for the write port
- waddr  input  ADDR_WIDTH  write register address
- wdata  input  DATA_WIDTH  write data
- rsv  input  1  reserve request: mark rsv_addr pending
- rsv_addr  input  ADDR_WIDTH  register being reserved by an issuing instruction
- raddr_a  input  ADDR_WIDTH  read port A address
- raddr_b  input  ADDR_WIDTH  read port B address
- rdata_a  output  DATA_WIDTH  read port A data, combinational
- rdata_b  output  DATA_WIDTH  read port B data, combinational
- pend_a  output  1  register at raddr_a is pending, combinational
- pend_b  output  1  register at raddr_b is pending, combinational

## Operation
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits plus a 2**ADDR_WIDTH-bit pending vector.
- Register 0: hardwired zero; writes to it ignored; reads return 0; never pending; rsv to 0 ignored.
- Write: on rising edge with rst=1, we=1, waddr!=0 -> reg[waddr] <= wdata; pending[waddr] cleared.
- Reserve: on rising edge with rst=1, rsv=1, rsv_addr!=0 -> pending[rsv_addr] set.
- Write and reserve same cycle, same address: reserve wins; register takes wdata, pending stays 1 (newer producer owns it).
- Write and reserve same cycle, different addresses: both take effect independently.
- Read (each port independently): if we=1 and waddr==raddr and raddr!=0 -> rdata = wdata (bypass); else rdata = reg[raddr].
- Pending output: pend = pending[raddr] AND NOT (we=1 and waddr==raddr); the arriving write resolves the hazard in the same cycle. Reserve in the current cycle does not affect pend until the next cycle.
- Both read ports may address the same register; results are identical.
- Out-of-range addresses impossible by width; no checking required.

## Timing
- Reset: rst=0 at a rising edge -> all registers 0, all pending bits 0 after that edge. Reset overrides we and rsv in the same cycle. Outputs after reset: rdata_a=rdata_b=0, pend_a=pend_b=0 (unless bypass active).
- Before first reset edge, contents are undefined; bench must apply reset first.
- Write latency: 0 cycles to readers via bypass; stored value visible without bypass from the cycle after the edge.
- Reserve latency: pending bit visible on pend_* from the cycle after the edge.
- Read paths purely combinational from raddr_*, we, waddr, wdata, and state; no registered outputs.
- Reset asserted mid-sequence discards all stored data and reservations; no partial state survives.

## Test plan
- Reset: write 0xDEADBEEF to r5, then rst=0 one cycle -> next cycle raddr_a=5 gives rdata_a=0, pend_a=0.
- Write/readback: write r1=0x00000011, r31=0xFFFFFFFF on consecutive cycles -> raddr_a=1, raddr_b=31 give 0x00000011 and 0xFFFFFFFF.
- Register 0: we=1, waddr=0, wdata=0x12345678; rsv=1, rsv_addr=0 -> raddr_a=0 gives 0 that cycle and after, pend_a=0.
- Bypass: r7 holds 0xA; drive we=1, waddr=7, wdata=0xB with raddr_a=raddr_b=7 -> both ports show 0xB same cycle, 0xB after edge with we=0.
- Scoreboard: rsv r9 -> next cycle pend_a=1 at raddr_a=9; write r9=0x55 -> pend_a=0 same cycle, rdata_a=0x55; next cycle pend_a=0.
- Collision: r4 pending; same cycle we=1, waddr=4, wdata=0x77 and rsv=1, rsv_addr=4 -> next cycle rdata=0x77, pend=1; reset then clears pend=0.
